// File: rtl/kcpsmx3_inc.sv
// Shared KCPSM3 ALU definitions: opcode and shift encodings, operand width and
// the packed response record that travels through the response FIFO.
package kcpsmx3_inc;

   localparam int OPERAND_WIDTH = 8;

   // Values follow the KCPSM3 instruction opcode field.
   typedef enum logic [4:0] {
      OP_LOAD    = 5'h00,
      OP_AND     = 5'h05,
      OP_OR      = 5'h06,
      OP_XOR     = 5'h07,
      OP_TEST    = 5'h09,
      OP_COMPARE = 5'h0A,
      OP_ADD     = 5'h0C,
      OP_ADDCY   = 5'h0D,
      OP_SUB     = 5'h0E,
      OP_SUBCY   = 5'h0F,
      OP_SHIFT   = 5'h10
   } opcode_t;

   typedef enum logic [1:0] {
      SHIFT_CONST = 2'd0,
      SHIFT_EXT   = 2'd1,
      SHIFT_CARRY = 2'd2,
      ROTATE      = 2'd3
   } shift_op_t;

   typedef struct packed {
      logic [OPERAND_WIDTH-1:0] result;
      logic                     zero;
      logic                     carry;
      logic                     err;
   } alu_rsp_t;

endpackage

// File: rtl/alu_op_responder_if.sv
// Request/response bundle between the ALU request driver and the responder.
interface alu_op_responder_if;
   import kcpsmx3_inc::*;

   logic                     req_valid;
   logic                     req_ready;
   opcode_t                  req_op;
   shift_op_t                req_shift_op;
   logic                     req_shift_dir;
   logic                     req_shift_const;
   logic                     req_carry_in;
   logic [OPERAND_WIDTH-1:0] req_operand_a;
   logic [OPERAND_WIDTH-1:0] req_operand_b;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [OPERAND_WIDTH-1:0] rsp_result;
   logic                     rsp_zero;
   logic                     rsp_carry;
   logic                     rsp_err;

   modport slave (
      input  req_valid, req_op, req_shift_op, req_shift_dir, req_shift_const,
             req_carry_in, req_operand_a, req_operand_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err
   );

   modport master (
      output req_valid, req_op, req_shift_op, req_shift_dir, req_shift_const,
             req_carry_in, req_operand_a, req_operand_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err
   );

endinterface

// File: rtl/alu_op_exec.sv
// Purely combinational KCPSM3 ALU/shift unit: request fields in, response
// record with KCPSM3 flag semantics out.
module alu_op_exec
   import kcpsmx3_inc::*;
(
   input  opcode_t                  op,
   input  shift_op_t                shift_op,
   input  logic                     shift_dir,
   input  logic                     shift_const,
   input  logic                     carry_in,
   input  logic [OPERAND_WIDTH-1:0] operand_a,
   input  logic [OPERAND_WIDTH-1:0] operand_b,
   output alu_rsp_t                 rsp
);

   localparam int W = OPERAND_WIDTH;

   logic [W-1:0] test_and;
   logic         shift_in;
   logic         zero_from_result;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves a latch.
      rsp              = '0;
      test_and         = operand_a & operand_b;
      shift_in         = 1'b0;
      zero_from_result = 1'b0;

      case (op)
         OP_LOAD: begin
            rsp.result = operand_b;
            rsp.carry  = carry_in;
         end
         OP_AND: begin
            rsp.result       = operand_a & operand_b;
            zero_from_result = 1'b1;
         end
         OP_OR: begin
            rsp.result       = operand_a | operand_b;
            zero_from_result = 1'b1;
         end
         OP_XOR: begin
            rsp.result       = operand_a ^ operand_b;
            zero_from_result = 1'b1;
         end
         OP_ADD, OP_ADDCY: begin
            {rsp.carry, rsp.result} = {1'b0, operand_a} + {1'b0, operand_b}
                                    + {{W{1'b0}}, carry_in & (op == OP_ADDCY)};
            zero_from_result = 1'b1;
         end
         OP_SUB, OP_SUBCY: begin
            // The bit above the result of the widened difference is the borrow.
            {rsp.carry, rsp.result} = {1'b0, operand_a} - {1'b0, operand_b}
                                    - {{W{1'b0}}, carry_in & (op == OP_SUBCY)};
            zero_from_result = 1'b1;
         end
         OP_COMPARE: begin
            rsp.result = operand_a;
            rsp.carry  = operand_a < operand_b;
            rsp.zero   = operand_a == operand_b;
         end
         OP_TEST: begin
            rsp.result = operand_a;
            rsp.zero   = test_and == '0;
            rsp.carry  = ^test_and;
         end
         OP_SHIFT: begin
            case (shift_op)
               SHIFT_CONST: shift_in = shift_const;
               SHIFT_EXT:   shift_in = shift_dir ? operand_a[W-1] : operand_a[0];
               SHIFT_CARRY: shift_in = carry_in;
               ROTATE:      shift_in = shift_dir ? operand_a[0] : operand_a[W-1];
               default:     shift_in = 1'b0;
            endcase
            if (shift_dir) begin
               rsp.carry  = operand_a[0];
               rsp.result = {shift_in, operand_a[W-1:1]};
            end else begin
               rsp.carry  = operand_a[W-1];
               rsp.result = {operand_a[W-2:0], shift_in};
            end
            zero_from_result = 1'b1;
         end
         default: rsp.err = 1'b1;
      endcase

      if (zero_from_result) rsp.zero = rsp.result == '0;
   end

endmodule

// File: rtl/alu_op_responder.sv
// Target-side ALU responder: executes one request per handshake and queues the
// response record in a small FIFO drained through rsp_valid/rsp_ready.
module alu_op_responder
   import kcpsmx3_inc::*;
#(
   parameter int RSP_DEPTH = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_op_responder_if.slave    bus,
   output logic [CNT_WIDTH-1:0] op_count
);

   localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int FILL_W = $clog2(RSP_DEPTH + 1);

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
   alu_rsp_t             mem_q [RSP_DEPTH];
   alu_rsp_t             exec_rsp;
   alu_rsp_t             head;
   logic                 push, pop;

   alu_op_exec u_exec (
      .op          (bus.req_op),
      .shift_op    (bus.req_shift_op),
      .shift_dir   (bus.req_shift_dir),
      .shift_const (bus.req_shift_const),
      .carry_in    (bus.req_carry_in),
      .operand_a   (bus.req_operand_a),
      .operand_b   (bus.req_operand_b),
      .rsp         (exec_rsp)
   );

   // Ready depends only on the fill level, never on rsp_ready.
   assign bus.req_ready = fill_q < FILL_W'(RSP_DEPTH);
   assign bus.rsp_valid = fill_q != '0;
   assign push          = bus.req_valid && bus.req_ready;
   assign pop           = bus.rsp_valid && bus.rsp_ready;

   assign head           = bus.rsp_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.rsp_result = head.result;
   assign bus.rsp_zero   = head.zero;
   assign bus.rsp_carry  = head.carry;
   assign bus.rsp_err    = head.err;
   assign op_count       = op_count_q;

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      op_count_d = (pop && op_count_q != '1) ? op_count_q + CNT_WIDTH'(1) : op_count_q;
      case ({push, pop})
         2'b10:   fill_d = fill_q + FILL_W'(1);
         2'b01:   fill_d = fill_q - FILL_W'(1);
         default: fill_d = fill_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         op_count_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         op_count_q <= op_count_d;
      end
   end

   // NOTE: storage is not reset; an empty FIFO masks the head to zero, so stale entries never show.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= exec_rsp;
   end

endmodule

// File: tb/tb_alu_op_responder.sv
// Self-checking bench: directed requests with literal expectations plus a
// per-cycle comparison against a queue-based behavioural model.
module tb_alu_op_responder;
   import kcpsmx3_inc::*;

   localparam int DEPTH = 2;

   typedef struct {
      int r;
      bit z;
      bit c;
      bit e;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] op_count;
   int          n_tests = 0;
   int          n_fail  = 0;

   exp_t        q[$];
   int          m_count;
   bit          m_acc, m_drn;

   alu_op_responder_if bus ();

   alu_op_responder #(.RSP_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .op_count (op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(opcode_t op, shift_op_t sop, bit dir, bit sc, bit ci,
                                  int a, int b);
      exp_t e;
      int   s;
      int   t;
      int   in_bit;
      e = '{0, 0, 0, 0};
      case (op)
         OP_LOAD:    begin e.r = b; e.c = ci; end
         OP_AND:     begin e.r = a & b; e.z = (e.r == 0); end
         OP_OR:      begin e.r = a | b; e.z = (e.r == 0); end
         OP_XOR:     begin e.r = a ^ b; e.z = (e.r == 0); end
         OP_ADD, OP_ADDCY: begin
            s   = a + b + ((op == OP_ADDCY) ? int'(ci) : 0);
            e.r = s % 256;
            e.c = s > 255;
            e.z = (e.r == 0);
         end
         OP_SUB, OP_SUBCY: begin
            s   = a - b - ((op == OP_SUBCY) ? int'(ci) : 0);
            e.c = s < 0;
            e.r = (s + 512) % 256;
            e.z = (e.r == 0);
         end
         OP_COMPARE: begin e.r = a; e.c = a < b; e.z = (a == b); end
         OP_TEST: begin
            t   = a & b;
            e.r = a;
            e.z = (t == 0);
            e.c = ($countones(t) % 2) == 1;
         end
         OP_SHIFT: begin
            case (sop)
               SHIFT_CONST: in_bit = int'(sc);
               SHIFT_EXT:   in_bit = dir ? int'(a >= 128) : a % 2;
               SHIFT_CARRY: in_bit = int'(ci);
               default:     in_bit = dir ? a % 2 : int'(a >= 128);
            endcase
            if (dir) begin
               e.c = (a % 2) == 1;
               e.r = a / 2 + in_bit * 128;
            end else begin
               e.c = a >= 128;
               e.r = (a * 2) % 256 + in_bit;
            end
            e.z = (e.r == 0);
         end
         default: e.e = 1'b1;
      endcase
      return e;
   endfunction

   // Model state advances on the same edges the DUT samples.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_count = 0;
      end else begin
         m_acc = bus.req_valid && (q.size() < DEPTH);
         m_drn = bus.rsp_ready && (q.size() > 0);
         if (m_drn) begin
            void'(q.pop_front());
            if (m_count < 65535) m_count++;
         end
         if (m_acc)
            q.push_back(model(bus.req_op, bus.req_shift_op, bus.req_shift_dir,
                              bus.req_shift_const, bus.req_carry_in,
                              int'(bus.req_operand_a), int'(bus.req_operand_b)));
      end
   end

   always @(negedge clk) begin
      check("cmp_rsp_valid", bus.rsp_valid, q.size() != 0);
      check("cmp_req_ready", bus.req_ready, q.size() < DEPTH);
      check("cmp_op_count", op_count, m_count);
      if (q.size() != 0) begin
         check("cmp_result", bus.rsp_result, q[0].r);
         check("cmp_zero", bus.rsp_zero, q[0].z);
         check("cmp_carry", bus.rsp_carry, q[0].c);
         check("cmp_err", bus.rsp_err, q[0].e);
      end else begin
         check("cmp_empty_head", {bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 0);
      end
   end

   task automatic set_req(input opcode_t op, input shift_op_t sop, input bit dir, input bit sc,
                          input bit ci, input logic [7:0] a, input logic [7:0] b);
      bus.req_valid       = 1'b1;
      bus.req_op          = op;
      bus.req_shift_op    = sop;
      bus.req_shift_dir   = dir;
      bus.req_shift_const = sc;
      bus.req_carry_in    = ci;
      bus.req_operand_a   = a;
      bus.req_operand_b   = b;
   endtask

   // Holds the current request until an edge with req_ready high has passed.
   task automatic wait_accept(input string name);
      int n;
      bit rdy;
      n = 0;
      do begin
         rdy = bus.req_ready;
         @(posedge clk);
         #2;
         n++;
      end while (!rdy && n < 50);
      if (!rdy) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: request not accepted within 50 cycles", name);
      end
   endtask

   // Single request into an empty FIFO, literal check of the head, then drain it.
   task automatic one(input string name, input opcode_t op, input shift_op_t sop, input bit dir,
                      input bit ci, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input bit ez, input bit ec);
      set_req(op, sop, dir, 1'b0, ci, a, b);
      wait_accept(name);
      bus.req_valid = 1'b0;
      check({name, "_valid"}, bus.rsp_valid, 1);
      check({name, "_result"}, bus.rsp_result, er);
      check({name, "_zero"}, bus.rsp_zero, ez);
      check({name, "_carry"}, bus.rsp_carry, ec);
      check({name, "_err"}, bus.rsp_err, 0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #2;
      bus.rsp_ready = 1'b0;
   endtask

   exp_t pin;

   initial begin
      rst_n = 1'b0;
      bus.rsp_ready = 1'b0;
      set_req(OP_LOAD, SHIFT_CONST, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      bus.req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("reset_req_ready", bus.req_ready, 1);
      check("reset_rsp_valid", bus.rsp_valid, 0);
      check("reset_op_count", op_count, 0);

      // Pin the model itself to hand-derived values.
      pin = model(OP_ADD, SHIFT_CONST, 0, 0, 0, 'hFF, 'h01);
      check("model_add_r", pin.r, 'h00);
      check("model_add_zc", {pin.z, pin.c}, 2'b11);
      pin = model(OP_SUB, SHIFT_CONST, 0, 0, 0, 'h00, 'h01);
      check("model_sub_r", pin.r, 'hFF);
      check("model_sub_zc", {pin.z, pin.c}, 2'b01);
      pin = model(OP_SHIFT, ROTATE, 0, 0, 0, 'h81, 'h00);
      check("model_rol_r", pin.r, 'h03);
      check("model_rol_c", pin.c, 1);

      one("add",     OP_ADD,     SHIFT_CONST, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 1);
      one("addcy",   OP_ADDCY,   SHIFT_CONST, 0, 1, 8'h10, 8'h20, 8'h31, 0, 0);
      one("sub",     OP_SUB,     SHIFT_CONST, 0, 0, 8'h00, 8'h01, 8'hFF, 0, 1);
      one("subcy",   OP_SUBCY,   SHIFT_CONST, 0, 1, 8'h00, 8'hFF, 8'h00, 1, 1);
      one("compare", OP_COMPARE, SHIFT_CONST, 0, 0, 8'h05, 8'h05, 8'h05, 1, 0);
      one("sr_carry", OP_SHIFT,  SHIFT_CARRY, 1, 1, 8'h01, 8'h00, 8'h80, 0, 1);
      one("sl_rot",  OP_SHIFT,   ROTATE,      0, 0, 8'h81, 8'h00, 8'h03, 0, 1);
      one("sl_ext",  OP_SHIFT,   SHIFT_EXT,   0, 0, 8'h80, 8'h00, 8'h00, 1, 1);
      one("test",    OP_TEST,    SHIFT_CONST, 0, 0, 8'h07, 8'h03, 8'h07, 0, 0);
      one("load",    OP_LOAD,    SHIFT_CONST, 0, 1, 8'h00, 8'h5A, 8'h5A, 0, 1);
      check("count_after_singles", op_count, 10);

      // Asynchronous reset with two entries queued.
      set_req(OP_AND, SHIFT_CONST, 0, 0, 0, 8'hF0, 8'h3C);
      wait_accept("rst_fill1");
      set_req(OP_OR, SHIFT_CONST, 0, 0, 0, 8'h01, 8'h02);
      wait_accept("rst_fill2");
      bus.req_valid = 1'b0;
      check("rst_two_queued", bus.req_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_valid", bus.rsp_valid, 0);
      check("rst_async_count", op_count, 0);
      check("rst_async_result", bus.rsp_result, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("rst_release_ready", bus.req_ready, 1);
      check("rst_release_valid", bus.rsp_valid, 0);

      // Backpressure: third request stalls until the drain starts.
      set_req(OP_ADD, SHIFT_CONST, 0, 0, 0, 8'h01, 8'h02);
      wait_accept("bp_first");
      set_req(OP_XOR, SHIFT_CONST, 0, 0, 0, 8'h0F, 8'hFF);
      wait_accept("bp_second");
      set_req(OP_OR, SHIFT_CONST, 0, 0, 0, 8'h00, 8'h00);
      check("bp_ready_low", bus.req_ready, 0);
      check("bp_head_first", bus.rsp_result, 8'h03);
      bus.rsp_ready = 1'b1;
      wait_accept("bp_third");
      bus.req_valid = 1'b0;
      check("bp_head_third", bus.rsp_result, 8'h00);
      check("bp_head_third_zero", bus.rsp_zero, 1);
      @(posedge clk);
      #2;
      bus.rsp_ready = 1'b0;
      check("bp_op_count", op_count, 3);
      check("bp_empty", bus.rsp_valid, 0);

      // Illegal opcode pushed while the head is popped.
      set_req(OP_ADD, SHIFT_CONST, 0, 0, 0, 8'h10, 8'h01);
      wait_accept("ill_pre");
      set_req(opcode_t'(5'h1F), SHIFT_CONST, 0, 0, 1, 8'hAA, 8'h55);
      bus.rsp_ready = 1'b1;
      wait_accept("ill_push");
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      check("ill_valid", bus.rsp_valid, 1);
      check("ill_ready_one_left", bus.req_ready, 1);
      check("ill_err", bus.rsp_err, 1);
      check("ill_result", bus.rsp_result, 8'h00);
      check("ill_flags", {bus.rsp_zero, bus.rsp_carry}, 2'b00);
      check("ill_count_mid", op_count, 4);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #2;
      bus.rsp_ready = 1'b0;
      check("ill_count_end", op_count, 5);
      check("ill_empty", bus.rsp_valid, 0);

      repeat (2) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_responder.md
Name: alu_op_responder

Overview:
- Target-side end of the ALU operation-request interface that the ALU stimulus path drives.
- Accepts one KCPSM3 ALU/shift request per handshake and executes it with KCPSM3 flag semantics.
- Queues {result, zero, carry, err} in a small response FIFO, drained through a valid/ready handshake.
- Sits between the request driver and the scoreboard/monitor; also usable as a standalone reference ALU with backpressure.

Parameters:
- OPERAND_WIDTH, 8: operand and result width; taken from kcpsmx3_inc.
- RSP_DEPTH, 2: response FIFO entries; power of 2, at least 2.
- CNT_WIDTH, 16: width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_op  in  opcode_t  ALU operation.
- req_shift_op  in  shift_op_t  shift/rotate kind; used only when req_op==SHIFT.
- req_shift_dir  in  1  shift direction: 0=left, 1=right.
- req_shift_const  in  1  bit shifted in for SHIFT_CONST.
- req_carry_in  in  1  carry flag input.
- req_operand_a  in  OPERAND_WIDTH  first operand (register sX).
- req_operand_b  in  OPERAND_WIDTH  second operand (sY or kk).
- rsp_valid  out  1  FIFO head is valid.
- rsp_ready  in  1  consumer accepts the head entry.
- rsp_result  out  OPERAND_WIDTH  result at FIFO head.
- rsp_zero  out  1  zero flag.
- rsp_carry  out  1  carry flag.
- rsp_err  out  1  head entry came from an illegal opcode.
- op_count  out  CNT_WIDTH  saturating count of responses drained.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, pointers and count 0.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_carry=0, rsp_err=0, op_count=0.
  - req_ready=1 on the first cycle after release.
- req_ready = (fifo_count < RSP_DEPTH). It is registered-state driven only, with no combinational path from rsp_ready.
- Accept occurs when req_valid && req_ready at a rising edge:
  - The result is computed combinationally from the request fields.
  - It is written into the FIFO on that same edge.
  - rsp_valid rises on the following cycle, giving 1-cycle latency when the FIFO was empty.
- Drain occurs when rsp_valid && rsp_ready at an edge:
  - The head is popped.
  - op_count increments and saturates at all-ones.
- Simultaneous push and pop: fifo_count is unchanged and order is preserved.
- Push and pop on a full FIFO: push is blocked because req_ready=0; pop proceeds.
- Pointers wrap modulo RSP_DEPTH. Outputs show the FIFO head and are 0 when empty.
- Requests held while req_ready=0 must not be lost or duplicated. The driver holds the request stable.
- Operation semantics (A=operand_a, B=operand_b, ci=carry_in, sums in OPERAND_WIDTH+1 bits):
  - LOAD: result=B, carry=ci, zero=0.
  - AND / OR / XOR: result=A op B, carry=0, zero=(result==0).
  - ADD / ADDCY: {carry,result}=A+B (+ci for ADDCY), zero=(result==0).
  - SUB / SUBCY: {borrow,result}=A-B (-ci for SUBCY), carry=borrow, zero=(result==0).
  - COMPARE: result=A (A is unchanged), carry=(A<B) unsigned, zero=(A==B).
  - TEST: t=A&B, result=A, zero=(t==0), carry=^t (odd parity).
  - SHIFT left (dir=0):
    - carry=A[MSB], result={A[MSB-1:0], in}.
    - in: SHIFT_CONST=shift_const, SHIFT_EXT=A[0], SHIFT_CARRY=ci, ROTATE=A[MSB].
  - SHIFT right (dir=1):
    - carry=A[0], result={in, A[MSB:1]}.
    - in: SHIFT_CONST=shift_const, SHIFT_EXT=A[MSB], SHIFT_CARRY=ci, ROTATE=A[0].
  - All shifts: zero=(result==0).
  - Any other opcode: result=0, carry=0, zero=0, err=1. The entry is still queued and counted.
- Reset asserted mid-operation: all queued entries are discarded immediately and outputs return to reset values asynchronously.

Decomposition:
- kcpsmx3_inc holds opcode_t, shift_op_t (SHIFT_CONST, SHIFT_EXT, SHIFT_CARRY, ROTATE), OPERAND_WIDTH, and a packed alu_rsp_t {result, zero, carry, err}.
- One sub-module, alu_op_exec: a purely combinational function from request fields to alu_rsp_t.
- The top level holds the FIFO, handshake logic and counter.

Test Plan:
- Reset check: assert rst_n=0 mid-burst with 2 entries queued -> rsp_valid=0, op_count=0, req_ready=1 after release.
- Adders: ADD A=8'hFF, B=8'h01, ci=0 -> result 8'h00, carry 1, zero 1. ADDCY A=8'h10, B=8'h20, ci=1 -> 8'h31, carry 0, zero 0.
- Subtract/compare: SUB A=8'h00, B=8'h01 -> result 8'hFF, carry 1, zero 0. COMPARE A=8'h05, B=8'h05 -> result 8'h05, zero 1, carry 0.
- Shifts and TEST:
  - SHIFT right SHIFT_CARRY A=8'h01, ci=1 -> result 8'h80, carry 1.
  - SHIFT left ROTATE A=8'h81 -> result 8'h03, carry 1.
  - TEST A=8'h07, B=8'h03 -> zero 0, carry 0.
- Backpressure: rsp_ready=0, issue 3 back-to-back requests -> first 2 accepted, req_ready=0 on the 3rd. Then raise rsp_ready -> results drain in order, the 3rd is accepted during the drain, op_count ends at 3.
- Illegal opcode plus concurrency: push an illegal opcode while popping the head in the same cycle -> fifo_count unchanged, the illegal entry is later drained with err=1 and result 8'h00.
